quad_encoder_gen: RTL

- Quadrature encoder emulator: the transmit-side counterpart of the encoder peripheral's quadrature decoder.
- Takes step commands (direction, step count) and drives Gray-coded A/B phase outputs.
- Phase edges are spaced by a programmable interval using the same (period << 6) timing convention as the peripheral's strobe timing.
- Used for loopback self-test of the decoder and for driving external quadrature inputs from the peripheral.

---
 rtl/quad_encoder_gen.sv | 102 ++++++++++
 1 files changed

// File: rtl/quad_encoder_gen.sv
`default_nettype none
// ============================================================================
// Module   : quad_encoder_gen
// Brief    : Quadrature encoder emulator; turns step commands into Gray-coded
//            A/B phase edges spaced by (period << 6) + 1 clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module quad_encoder_gen #(
    parameter int WIDTH   = 16,
    parameter int STEPS_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         period,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [STEPS_W-1:0] cmd_steps,
    input  logic               abort,
    output logic               enc_a,
    output logic               enc_b,
    output logic               busy,
    output logic               done,
    output logic [15:0]        position
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0]   c_presc_one = WIDTH'(1);
    localparam logic [STEPS_W-1:0] c_step_one  = STEPS_W'(1);
    localparam logic [15:0]        c_pos_one   = 16'd1;
    localparam logic [1:0]         c_phase_one = 2'd1;

    state_t             r_state;
    logic [1:0]         r_phase;
    logic               r_dir;
    logic [STEPS_W-1:0] r_remaining;
    logic [WIDTH-1:0]   r_interval;
    logic [WIDTH-1:0]   r_prescaler;
    logic               r_done;
    logic [15:0]        r_position;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= 2'd0;
            r_dir       <= 1'b0;
            r_remaining <= '0;
            r_interval  <= '0;
            r_prescaler <= '0;
            r_done      <= 1'b0;
            r_position  <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_steps != '0) begin
                            r_dir       <= cmd_dir;
                            r_remaining <= cmd_steps;
                            // Interval is frozen for the whole command
                            r_interval  <= WIDTH'(period) << 6;
                            r_prescaler <= '0;
                            r_state     <= S_RUN;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_prescaler >= r_interval) begin
                        r_prescaler <= '0;
                        r_phase     <= r_dir ? r_phase + c_phase_one : r_phase - c_phase_one;
                        r_position  <= r_dir ? r_position + c_pos_one : r_position - c_pos_one;
                        r_remaining <= r_remaining - c_step_one;
                        if (r_remaining == c_step_one) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_prescaler <= r_prescaler + c_presc_one;
                    end
                end
            endcase
        end
    end

    // Phase sequence 0,1,2,3 -> AB = 00,10,11,01
    assign enc_a     = r_phase[1] ^ r_phase[0];
    assign enc_b     = r_phase[1];
    assign busy      = (r_state == S_RUN);
    assign cmd_ready = (r_state == S_IDLE);
    assign done      = r_done;
    assign position  = r_position;

endmodule
`default_nettype wire
